// File: rtl/wb_forward_unit.sv
// -----------------------------------------------------------------------------
// wb_forward_unit
//
// Write-back and forwarding unit for the dual-pipe datapath. Each cycle the
// even-pipe (1) and odd-pipe (2) results enter slot 0 of a per-pipe history
// DEPTH slots deep, counting down their remaining latency as they age. The
// oldest slot of each pipe is copied into a retire register that drives the
// register-file write ports. Six operand queries are resolved against the
// in-flight results (youngest first): a ready match forwards its data, and a
// match that is not ready yet raises a hazard.
//
// Build option:
//   WB_FORWARD_EN  defined   : ready matches are forwarded.
//                  undefined : no forwarding; any match raises a hazard until
//                              the value has reached the register file.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   regWriteEnable_in1/2            pipe result writes RT (0 = bubble)
//   result_in1/2                    128-bit result value
//   registerRT_in1/2                destination register
//   latency_in1/2                   cycles until the result is valid
//   srcReg_in[5:0], srcValid_in     queries: 0-2 pipe1 RA/RB/RC, 3-5 pipe2
//   fwdData_out, fwdHit_out         forwarded value / ready match found
//   hazard_out, stall_out           youngest match not ready / OR of hazards
//   rfWriteEnable_out1/2,
//   rfAddr_out1/2, rfData_out1/2    register-file write port (retire register)
// -----------------------------------------------------------------------------
module wb_forward_unit #(
  parameter int DEPTH = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regWriteEnable_in1,
  input  logic              regWriteEnable_in2,
  input  logic [127:0]      result_in1,
  input  logic [127:0]      result_in2,
  input  logic [6:0]        registerRT_in1,
  input  logic [6:0]        registerRT_in2,
  input  logic [2:0]        latency_in1,
  input  logic [2:0]        latency_in2,
  input  logic [5:0][6:0]   srcReg_in,
  input  logic [5:0]        srcValid_in,
  output logic [5:0][127:0] fwdData_out,
  output logic [5:0]        fwdHit_out,
  output logic [5:0]        hazard_out,
  output logic              stall_out,
  output logic              rfWriteEnable_out1,
  output logic              rfWriteEnable_out2,
  output logic [6:0]        rfAddr_out1,
  output logic [6:0]        rfAddr_out2,
  output logic [127:0]      rfData_out1,
  output logic [127:0]      rfData_out2
);

  typedef struct packed {
    logic         we;
    logic [6:0]   rt;
    logic [127:0] data;
    logic [2:0]   lat;
  } slot_t;

  // Candidate order used by the lookup: slot k pipe2 at 2k, slot k pipe1 at
  // 2k+1, then retire pipe2, then retire pipe1. Lower index = younger.
  localparam int NCAND = 2 * DEPTH + 2;
  localparam int SELW  = $clog2(NCAND);

  slot_t        p1_q [DEPTH];
  slot_t        p1_d [DEPTH];
  slot_t        p2_q [DEPTH];
  slot_t        p2_d [DEPTH];

  logic         ret1_we_q, ret1_we_d;
  logic [6:0]   ret1_rt_q, ret1_rt_d;
  logic [127:0] ret1_data_q, ret1_data_d;
  logic         ret2_we_q, ret2_we_d;
  logic [6:0]   ret2_rt_q, ret2_rt_d;
  logic [127:0] ret2_data_q, ret2_data_d;

  function automatic logic [2:0] dec_sat(input logic [2:0] v);
    dec_sat = (v == 3'd0) ? 3'd0 : v - 3'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // History shift: slot 0 takes the new results, every older slot takes its
  // younger neighbour, latency counting down on every move.
  // ---------------------------------------------------------------------------
  assign p1_d[0] = '{we: regWriteEnable_in1, rt: registerRT_in1,
                     data: result_in1, lat: dec_sat(latency_in1)};
  assign p2_d[0] = '{we: regWriteEnable_in2, rt: registerRT_in2,
                     data: result_in2, lat: dec_sat(latency_in2)};

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_shift
      assign p1_d[gi] = '{we: p1_q[gi-1].we, rt: p1_q[gi-1].rt,
                          data: p1_q[gi-1].data, lat: dec_sat(p1_q[gi-1].lat)};
      assign p2_d[gi] = '{we: p2_q[gi-1].we, rt: p2_q[gi-1].rt,
                          data: p2_q[gi-1].data, lat: dec_sat(p2_q[gi-1].lat)};
    end
  endgenerate

  // Retire: when both pipes retire to the same register, the pipe1 write is
  // dropped so the younger pipe2 value is what ends up in the register file.
  assign ret2_we_d   = p2_q[DEPTH-1].we;
  assign ret2_rt_d   = p2_q[DEPTH-1].rt;
  assign ret2_data_d = p2_q[DEPTH-1].data;
  assign ret1_we_d   = p1_q[DEPTH-1].we &
                       ~(p2_q[DEPTH-1].we && (p2_q[DEPTH-1].rt == p1_q[DEPTH-1].rt));
  assign ret1_rt_d   = p1_q[DEPTH-1].rt;
  assign ret1_data_d = p1_q[DEPTH-1].data;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        p1_q[k] <= '0;
        p2_q[k] <= '0;
      end
      ret1_we_q   <= 1'b0;
      ret1_rt_q   <= '0;
      ret1_data_q <= '0;
      ret2_we_q   <= 1'b0;
      ret2_rt_q   <= '0;
      ret2_data_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        p1_q[k] <= p1_d[k];
        p2_q[k] <= p2_d[k];
      end
      ret1_we_q   <= ret1_we_d;
      ret1_rt_q   <= ret1_rt_d;
      ret1_data_q <= ret1_data_d;
      ret2_we_q   <= ret2_we_d;
      ret2_rt_q   <= ret2_rt_d;
      ret2_data_q <= ret2_data_d;
    end
  end

  assign rfWriteEnable_out1 = ret1_we_q;
  assign rfAddr_out1        = ret1_rt_q;
  assign rfData_out1        = ret1_data_q;
  assign rfWriteEnable_out2 = ret2_we_q;
  assign rfAddr_out2        = ret2_rt_q;
  assign rfData_out2        = ret2_data_q;

  // ---------------------------------------------------------------------------
  // Flattened candidate list, youngest first.
  // ---------------------------------------------------------------------------
  logic         cand_we   [NCAND];
  logic [6:0]   cand_rt   [NCAND];
`ifdef WB_FORWARD_EN
  logic         cand_rdy  [NCAND];
  logic [127:0] cand_data [NCAND];
`endif

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cand
      assign cand_we[2*gi]   = p2_q[gi].we;
      assign cand_rt[2*gi]   = p2_q[gi].rt;
      assign cand_we[2*gi+1] = p1_q[gi].we;
      assign cand_rt[2*gi+1] = p1_q[gi].rt;
`ifdef WB_FORWARD_EN
      assign cand_rdy[2*gi]    = (p2_q[gi].lat == 3'd0);
      assign cand_data[2*gi]   = p2_q[gi].data;
      assign cand_rdy[2*gi+1]  = (p1_q[gi].lat == 3'd0);
      assign cand_data[2*gi+1] = p1_q[gi].data;
`endif
    end
  endgenerate

  // The retire register bridges the gap until the register file is written,
  // and is always ready.
  assign cand_we[2*DEPTH]   = ret2_we_q;
  assign cand_rt[2*DEPTH]   = ret2_rt_q;
  assign cand_we[2*DEPTH+1] = ret1_we_q;
  assign cand_rt[2*DEPTH+1] = ret1_rt_q;
`ifdef WB_FORWARD_EN
  assign cand_rdy[2*DEPTH]    = 1'b1;
  assign cand_data[2*DEPTH]   = ret2_data_q;
  assign cand_rdy[2*DEPTH+1]  = 1'b1;
  assign cand_data[2*DEPTH+1] = ret1_data_q;
`endif

  // ---------------------------------------------------------------------------
  // Per-query lookup. The scan runs oldest to youngest so the last match
  // written is the youngest one.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_query
      logic            found_c;
`ifdef WB_FORWARD_EN
      logic [SELW-1:0] sel_c;
`endif

      always_comb begin
        found_c = 1'b0;
`ifdef WB_FORWARD_EN
        sel_c   = '0;
`endif
        for (int c = NCAND - 1; c >= 0; c--) begin
          if (cand_we[c] && (cand_rt[c] == srcReg_in[gi])) begin
            found_c = 1'b1;
`ifdef WB_FORWARD_EN
            sel_c   = SELW'(c);
`endif
          end
        end
      end

`ifdef WB_FORWARD_EN
      assign fwdHit_out[gi]  = srcValid_in[gi] & found_c & cand_rdy[sel_c];
      assign hazard_out[gi]  = srcValid_in[gi] & found_c & ~cand_rdy[sel_c];
      assign fwdData_out[gi] = fwdHit_out[gi] ? cand_data[sel_c] : 128'd0;
`else
      assign fwdHit_out[gi]  = 1'b0;
      assign hazard_out[gi]  = srcValid_in[gi] & found_c;
      assign fwdData_out[gi] = 128'd0;
`endif
    end
  endgenerate

  assign stall_out = |hazard_out;

endmodule

// File: tb/tb_wb_forward_unit.sv
// -----------------------------------------------------------------------------
// tb_wb_forward_unit
//
// Directed bench for wb_forward_unit. A reference model records every input
// sampled at each clock edge and derives the expected outputs from the age of
// each recorded result (slot = age, retire = age DEPTH, remaining latency =
// latency_in-1-age clipped at 0). A compare process checks all outputs on
// every falling edge; directed sequences add hand-computed literal checks.
// Works in both builds (WB_FORWARD_EN defined or not).
// -----------------------------------------------------------------------------
module tb_wb_forward_unit;

  localparam int DEPTH = 7;
  localparam int MAXE  = 1024;
`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              we1, we2;
  logic [127:0]      dat1, dat2;
  logic [6:0]        rt1, rt2;
  logic [2:0]        lat1, lat2;
  logic [5:0][6:0]   src_reg;
  logic [5:0]        src_val;
  logic [5:0][127:0] fwd_data;
  logic [5:0]        fwd_hit;
  logic [5:0]        hazard;
  logic              stall;
  logic              rf_we1, rf_we2;
  logic [6:0]        rf_addr1, rf_addr2;
  logic [127:0]      rf_data1, rf_data2;

  int checks = 0;
  int errors = 0;

  wb_forward_unit #(.DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .regWriteEnable_in1(we1),
    .regWriteEnable_in2(we2),
    .result_in1        (dat1),
    .result_in2        (dat2),
    .registerRT_in1    (rt1),
    .registerRT_in2    (rt2),
    .latency_in1       (lat1),
    .latency_in2       (lat2),
    .srcReg_in         (src_reg),
    .srcValid_in       (src_val),
    .fwdData_out       (fwd_data),
    .fwdHit_out        (fwd_hit),
    .hazard_out        (hazard),
    .stall_out         (stall),
    .rfWriteEnable_out1(rf_we1),
    .rfWriteEnable_out2(rf_we2),
    .rfAddr_out1       (rf_addr1),
    .rfAddr_out2       (rf_addr2),
    .rfData_out1       (rf_data1),
    .rfData_out2       (rf_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: per-edge record of sampled inputs.
  // ---------------------------------------------------------------------------
  logic         rec_we   [1:2][0:MAXE-1];
  logic [6:0]   rec_rt   [1:2][0:MAXE-1];
  logic [2:0]   rec_lat  [1:2][0:MAXE-1];
  logic [127:0] rec_data [1:2][0:MAXE-1];
  int           tn       = 0;
  int           last_rst = -1;
  bit           started  = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      last_rst = tn;
      started  = 1'b1;
    end
    rec_we[1][tn]   = we1;
    rec_rt[1][tn]   = rt1;
    rec_lat[1][tn]  = lat1;
    rec_data[1][tn] = dat1;
    rec_we[2][tn]   = we2;
    rec_rt[2][tn]   = rt2;
    rec_lat[2][tn]  = lat2;
    rec_data[2][tn] = dat2;
    tn++;
  end

  // Youngest valid match for register r among results aged 0..DEPTH edges.
  function automatic void model_lookup(input logic [6:0] r, output bit found,
                                       output bit ready, output logic [127:0] data);
    found = 1'b0;
    ready = 1'b0;
    data  = '0;
    for (int a = 0; a <= DEPTH; a++) begin
      int e;
      e = tn - 1 - a;
      if (!found && e > last_rst) begin
        for (int p = 2; p >= 1; p--) begin
          if (!found && rec_we[p][e] && rec_rt[p][e] == r) begin
            int rem;
            rem   = (a == DEPTH) ? 0 : int'(rec_lat[p][e]) - 1 - a;
            found = 1'b1;
            ready = (rem <= 0);
            data  = rec_data[p][e];
          end
        end
      end
    end
  endfunction

  bit           m_f, m_r, m_v;
  logic         e_hit, e_haz, e_we1, e_we2;
  logic [127:0] m_d, e_data;
  int           m_e;

  always @(negedge clk) begin
    if (started) begin
      for (int q = 0; q < 6; q++) begin
        model_lookup(src_reg[q], m_f, m_r, m_d);
        if (FWD) begin
          e_hit  = src_val[q] && m_f && m_r;
          e_haz  = src_val[q] && m_f && !m_r;
          e_data = e_hit ? m_d : 128'd0;
        end else begin
          e_hit  = 1'b0;
          e_haz  = src_val[q] && m_f;
          e_data = 128'd0;
        end
        chk($sformatf("model_hit[%0d]", q), 128'(fwd_hit[q]), 128'(e_hit));
        chk($sformatf("model_haz[%0d]", q), 128'(hazard[q]), 128'(e_haz));
        chk($sformatf("model_data[%0d]", q), fwd_data[q], e_data);
      end
      model_lookup(7'd0, m_f, m_r, m_d);
      chk("model_stall", 128'(stall), 128'(|hazard));
      m_e = tn - 1 - DEPTH;
      m_v = (m_e > last_rst);
      e_we2 = m_v ? rec_we[2][m_e] : 1'b0;
      e_we1 = m_v ? (rec_we[1][m_e] && !(rec_we[2][m_e] && rec_rt[2][m_e] == rec_rt[1][m_e])) : 1'b0;
      chk("model_rf_we1", 128'(rf_we1), 128'(e_we1));
      chk("model_rf_we2", 128'(rf_we2), 128'(e_we2));
      if (e_we1) begin
        chk("model_rf_addr1", 128'(rf_addr1), 128'(rec_rt[1][m_e]));
        chk("model_rf_data1", rf_data1, rec_data[1][m_e]);
      end
      if (e_we2) begin
        chk("model_rf_addr2", 128'(rf_addr2), 128'(rec_rt[2][m_e]));
        chk("model_rf_data2", rf_data2, rec_data[2][m_e]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    we1 = 1'b0; rt1 = '0; lat1 = '0; dat1 = '0;
    we2 = 1'b0; rt2 = '0; lat2 = '0; dat2 = '0;
  endtask

  task automatic issue(input bit w1, input int r1, input int l1, input logic [127:0] d1,
                       input bit w2, input int r2, input int l2, input logic [127:0] d2);
    we1 = w1; rt1 = 7'(r1); lat1 = 3'(l1); dat1 = d1;
    we2 = w2; rt2 = 7'(r2); lat2 = 3'(l2); dat2 = d2;
    $display("issue p1 we=%0d rt=%0d lat=%0d data=%0h | p2 we=%0d rt=%0d lat=%0d data=%0h",
             w1, r1, l1, d1, w2, r2, l2, d2);
  endtask

  initial begin
    reset   = 1'b1;
    bubble();
    src_reg = '0;
    src_val = '0;
    tick();
    tick();
    reset = 1'b0;

    // Stale state, then reset: everything must come back cleared.
    issue(1, 30, 0, 128'h55, 1, 31, 2, 128'h66);
    tick(); tick(); tick();
    reset = 1'b1;
    bubble();
    tick();
    reset = 1'b0;
    src_reg[0] = 7'd30;
    src_reg[3] = 7'd31;
    src_val    = 6'b001001;
    #1;
    chk("rst_rf_we1", 128'(rf_we1), 128'd0);
    chk("rst_rf_we2", 128'(rf_we2), 128'd0);
    chk("rst_hit", 128'(fwd_hit), 128'd0);
    chk("rst_haz", 128'(hazard), 128'd0);
    chk("rst_stall", 128'(stall), 128'd0);

    // Single ready write to r5: on the write port exactly DEPTH edges later.
    issue(1, 5, 0, 128'hAA, 0, 0, 0, 128'h0);
    src_reg[0] = 7'd5;
    src_val    = 6'b000001;
    tick();
    bubble();
    #1;
    chk("pulse_hit0", 128'(fwd_hit[0]), 128'(FWD));
    chk("pulse_haz0", 128'(hazard[0]), 128'(!FWD));
    for (int k = 1; k <= DEPTH + 1; k++) begin
      tick();
      chk($sformatf("pulse_we1_k%0d", k), 128'(rf_we1), 128'(k == DEPTH));
      if (k == DEPTH) begin
        chk("pulse_addr1", 128'(rf_addr1), 128'd5);
        chk("pulse_data1", rf_data1, 128'hAA);
      end
    end

    // Latency 4 on r9: hazard for the first three observations, then forward.
    issue(1, 9, 4, 128'h99, 0, 0, 0, 128'h0);
    src_reg[0] = 7'd9;
    for (int k = 0; k <= DEPTH + 1; k++) begin
      tick();
      if (k == 0) bubble();
      #1;
      chk($sformatf("lat4_haz_k%0d", k), 128'(hazard[0]),
          128'(FWD ? (k <= 2) : (k <= DEPTH)));
      chk($sformatf("lat4_hit_k%0d", k), 128'(fwd_hit[0]),
          128'(FWD && k >= 3 && k <= DEPTH));
      chk($sformatf("lat4_data_k%0d", k), fwd_data[0],
          (FWD && k >= 3 && k <= DEPTH) ? 128'h99 : 128'h0);
    end

    // Same-cycle writes to r12: pipe2 wins for forwarding and retire.
    issue(1, 12, 0, 128'h1, 1, 12, 0, 128'h2);
    src_reg[3] = 7'd12;
    src_val    = 6'b001000;
    for (int k = 0; k <= DEPTH + 1; k++) begin
      tick();
      if (k == 0) begin
        bubble();
        #1;
        chk("same_data3", fwd_data[3], FWD ? 128'h2 : 128'h0);
        chk("same_haz3", 128'(hazard[3]), 128'(!FWD));
      end
      if (k == DEPTH) begin
        chk("same_rf_we1", 128'(rf_we1), 128'd0);
        chk("same_rf_we2", 128'(rf_we2), 128'd1);
        chk("same_rf_addr2", 128'(rf_addr2), 128'd12);
        chk("same_rf_data2", rf_data2, 128'h2);
      end
    end

    // Older ready r3 shadowed by a younger, not-ready r3.
    issue(1, 3, 0, 128'h7, 0, 0, 0, 128'h0);
    src_reg[1] = 7'd3;
    src_val    = 6'b000010;
    tick();
    issue(1, 3, 5, 128'h8, 0, 0, 0, 128'h0);
    #1;
    chk("older_hit1", 128'(fwd_hit[1]), 128'(FWD));
    chk("older_data1", fwd_data[1], FWD ? 128'h7 : 128'h0);
    tick();
    bubble();
    #1;
    chk("younger_haz1", 128'(hazard[1]), 128'd1);
    chk("younger_hit1", 128'(fwd_hit[1]), 128'd0);
    chk("younger_data1", fwd_data[1], 128'h0);
    for (int k = 0; k < DEPTH + 2; k++) tick();

    // Reset with four results in flight: no write pulse afterwards.
    src_reg[0] = 7'd40;
    src_val    = 6'b000001;
    for (int i = 0; i < 4; i++) begin
      issue(1, 40 + i, i, 128'(32'h400 + i), 1, 50 + i, 0, 128'(32'h500 + i));
      tick();
    end
    reset = 1'b1;
    bubble();
    tick();
    reset = 1'b0;
    #1;
    chk("flight_haz0", 128'(hazard[0]), 128'd0);
    chk("flight_hit0", 128'(fwd_hit[0]), 128'd0);
    for (int k = 1; k <= DEPTH + 1; k++) begin
      tick();
      chk($sformatf("flight_we1_k%0d", k), 128'(rf_we1), 128'd0);
      chk($sformatf("flight_we2_k%0d", k), 128'(rf_we2), 128'd0);
    end

    // Ready r20 on query 5: forwarded, or a hazard until it leaves retire.
    issue(1, 20, 0, 128'h20, 0, 0, 0, 128'h0);
    src_reg[5] = 7'd20;
    src_val    = 6'b100000;
    for (int k = 0; k <= DEPTH + 1; k++) begin
      tick();
      if (k == 0) bubble();
      #1;
      chk($sformatf("r20_haz_k%0d", k), 128'(hazard[5]), 128'(!FWD && k <= DEPTH));
      chk($sformatf("r20_hit_k%0d", k), 128'(fwd_hit[5]), 128'(FWD && k <= DEPTH));
      chk($sformatf("r20_stall_k%0d", k), 128'(stall), 128'(!FWD && k <= DEPTH));
    end

    // Mixed traffic with a mid-stream reset, checked by the model only.
    for (int i = 0; i < 48; i++) begin
      issue((i % 3) != 2, 1 + (i % 5), i % 8, 128'(i * 32'h1111 + 1),
            (i % 4) != 0, 1 + ((i * 3) % 5), (i * 5) % 8, {96'h0, 32'hF000 + 32'(i)});
      for (int q = 0; q < 6; q++) src_reg[q] = 7'(1 + ((i + q) % 6));
      src_val = ((i % 7) == 0) ? 6'b010111 : 6'b111111;
      reset   = (i == 30);
      tick();
    end
    reset = 1'b0;
    bubble();
    for (int k = 0; k < DEPTH + 2; k++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
